// File: rtl/jtag_shift_pkg.sv
// Shared opcode/state encodings and default sizing for the JTAG shift engine.
package jtag_shift_pkg;

  localparam int unsigned JTAG_W_DEFAULT          = 32;
  localparam int unsigned JTAG_DIV_W_DEFAULT      = 16;
  localparam int unsigned JTAG_TICK_DELAY_DEFAULT = 50;

  typedef enum logic [1:0] {
    OP_SHIFT   = 2'd0,
    OP_TMS_SEQ = 2'd1,
    OP_TRST    = 2'd2,
    OP_SET_DIV = 2'd3
  } jtag_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_TRST,
    ST_RSP
  } jtag_state_e;

endpackage

// File: rtl/jtag_tck_divider.sv
// Half-period tick generator: tick fires after reload_val+1 enabled clocks.
module jtag_tck_divider #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned TICK_DELAY = 50
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             reload,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = enable && (cnt == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= DIV_W'(TICK_DELAY);
    end else if (enable) begin
      if (reload) begin
        cnt <= reload_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtag_shift_engine.sv
// Command-driven JTAG shifter: SHIFT/TMS_SEQ/TRST/SET_DIV commands, one response each.
module jtag_shift_engine
  import jtag_shift_pkg::*;
#(
  parameter int unsigned W          = JTAG_W_DEFAULT,
  parameter int unsigned DIV_W      = JTAG_DIV_W_DEFAULT,
  parameter int unsigned TICK_DELAY = JTAG_TICK_DELAY_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               init_done,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [$clog2(W):0] cmd_len,
  input  logic [W-1:0]       cmd_tms,
  input  logic [W-1:0]       cmd_tdi,
  input  logic               cmd_last,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_tdo,
  output logic               rsp_undriven,
  output logic               jtag_TCK,
  output logic               jtag_TMS,
  output logic               jtag_TDI,
  output logic               jtag_TRSTn,
  input  logic               jtag_TDO_data,
  input  logic               jtag_TDO_driven,
  output logic               busy
);

  localparam int unsigned LW = $clog2(W) + 1;
  localparam int unsigned HW = LW + 1;
  localparam logic [LW-1:0] W_LEN = LW'(W);

  jtag_state_e      state;
  jtag_op_e         op_in;
  jtag_op_e         op_q;
  logic             last_q;
  logic             init_done_sticky;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             reload;
  logic             accept;
  logic [LW-1:0]    len_eff;
  logic [LW-1:0]    rem;
  logic [HW-1:0]    hp;
  logic [W-1:0]     tdi_sr;
  logic [W-1:0]     tms_sr;
  logic [W-1:0]     bit_mask;

  assign op_in     = jtag_op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE) && init_done_sticky && enable;
  assign accept    = cmd_valid && cmd_ready;
  assign len_eff   = (cmd_len > W_LEN) ? W_LEN : cmd_len;
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RSP);

  // Every state change happens on accept or on a tick, so both restart the half period.
  assign reload = accept || tick;

  jtag_tck_divider #(
    .DIV_W      (DIV_W),
    .TICK_DELAY (TICK_DELAY)
  ) u_tck_divider (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .reload     (reload),
    .reload_val (div_q),
    .tick       (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      init_done_sticky <= 1'b0;
    end else if (init_done) begin
      init_done_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      op_q         <= OP_SHIFT;
      last_q       <= 1'b0;
      div_q        <= DIV_W'(TICK_DELAY);
      rem          <= '0;
      hp           <= '0;
      tdi_sr       <= '0;
      tms_sr       <= '0;
      bit_mask     <= '0;
      rsp_tdo      <= '0;
      rsp_undriven <= 1'b0;
      jtag_TCK     <= 1'b0;
      jtag_TMS     <= 1'b1;
      jtag_TDI     <= 1'b0;
      jtag_TRSTn   <= 1'b1;
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q         <= op_in;
            last_q       <= cmd_last;
            rsp_tdo      <= '0;
            rsp_undriven <= 1'b0;
            case (op_in)
              OP_SHIFT, OP_TMS_SEQ: begin
                if (len_eff == '0) begin
                  state <= ST_RSP;
                end else begin
                  state    <= ST_LOW;
                  jtag_TCK <= 1'b0;
                  jtag_TDI <= cmd_tdi[0];
                  jtag_TMS <= (op_in == OP_TMS_SEQ) ? cmd_tms[0]
                                                    : ((len_eff == LW'(1)) && cmd_last);
                  tdi_sr   <= cmd_tdi >> 1;
                  tms_sr   <= cmd_tms >> 1;
                  rem      <= len_eff;
                  bit_mask <= W'(1);
                end
              end
              OP_TRST: begin
                if (cmd_len == '0) begin
                  state <= ST_RSP;
                end else begin
                  // Reset is held for 2*len half periods of the current divider.
                  state      <= ST_TRST;
                  jtag_TCK   <= 1'b0;
                  jtag_TRSTn <= 1'b0;
                  hp         <= {cmd_len, 1'b0};
                end
              end
              default: begin
                div_q <= cmd_tdi[DIV_W-1:0];
                state <= ST_RSP;
              end
            endcase
          end
        end

        ST_LOW: begin
          if (tick) begin
            state    <= ST_HIGH;
            jtag_TCK <= 1'b1;
            if (jtag_TDO_driven) begin
              if (jtag_TDO_data) begin
                rsp_tdo <= rsp_tdo | bit_mask;
              end
            end else begin
              rsp_undriven <= 1'b1;
            end
          end
        end

        ST_HIGH: begin
          if (tick) begin
            jtag_TCK <= 1'b0;
            if (rem > LW'(1)) begin
              state    <= ST_LOW;
              rem      <= rem - LW'(1);
              bit_mask <= bit_mask << 1;
              jtag_TDI <= tdi_sr[0];
              tdi_sr   <= tdi_sr >> 1;
              tms_sr   <= tms_sr >> 1;
              // rem==2 here means the bit being loaded is the final one.
              jtag_TMS <= (op_q == OP_TMS_SEQ) ? tms_sr[0]
                                               : ((rem == LW'(2)) && last_q);
            end else begin
              state <= ST_RSP;
            end
          end
        end

        ST_TRST: begin
          if (tick) begin
            if (hp == HW'(1)) begin
              state      <= ST_RSP;
              jtag_TRSTn <= 1'b1;
            end else begin
              hp <= hp - HW'(1);
            end
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Self-checking bench for jtag_shift_engine: directed table, corner sequences, random vs model.
module tb_jtag_shift_engine;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        init_done;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_tms;
  logic [31:0] cmd_tdi;
  logic        cmd_last;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_tdo;
  logic        rsp_undriven;
  logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic        jtag_TDO_data, jtag_TDO_driven;
  logic        busy;
  logic [7:0]  pins;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_div = 50;

  localparam int LIMIT = 20000;

  assign pins = {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, cmd_ready, rsp_valid, rsp_undriven, busy};

  jtag_shift_engine #(
    .W          (32),
    .DIV_W      (16),
    .TICK_DELAY (50)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .init_done       (init_done),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_len         (cmd_len),
    .cmd_tms         (cmd_tms),
    .cmd_tdi         (cmd_tdi),
    .cmd_last        (cmd_last),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_tdo         (rsp_tdo),
    .rsp_undriven    (rsp_undriven),
    .jtag_TCK        (jtag_TCK),
    .jtag_TMS        (jtag_TMS),
    .jtag_TDI        (jtag_TDI),
    .jtag_TRSTn      (jtag_TRSTn),
    .jtag_TDO_data   (jtag_TDO_data),
    .jtag_TDO_driven (jtag_TDO_driven),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: behaviour expressed directly from the command semantics.
  function automatic int eff_len(input logic [1:0] op, input logic [5:0] len);
    if (op > 2'd1) return 0;
    return (len > 6'd32) ? 32 : int'(len);
  endfunction

  function automatic logic [31:0] model_tdo(input int n, input logic [31:0] d, input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) if (v[i] && d[i]) r = r | (32'h1 << i);
    return r;
  endfunction

  function automatic logic model_und(input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) if (!v[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [5:0] len, input int div);
    case (op)
      2'd0, 2'd1: return eff_len(op, len) * 2 * (div + 1);
      2'd2:       return int'(len) * 2 * (div + 1);
      default:    return 0;
    endcase
  endfunction

  function automatic logic model_tms(input logic [1:0] op, input int i, input int n,
                                     input logic [31:0] tms, input logic last);
    if (op == 2'd1) return tms[i];
    return (i == n - 1) ? last : 1'b0;
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] tms,
                          input logic [31:0] tdi, input logic last, output bit ok);
    int g;
    logic rdy;
    cmd_op = op; cmd_len = len; cmd_tms = tms; cmd_tdi = tdi; cmd_last = last;
    cmd_valid = 1'b1;
    ok = 1'b0;
    g = 0;
    while (!ok && g < 200) begin
      rdy = cmd_ready;
      @(posedge clock); #1;
      g++;
      if (rdy) ok = 1'b1;
    end
    cmd_valid = 1'b0;
    check("cmd accepted", 64'(ok), 64'd1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] tms,
                         input logic [31:0] tdi, input logic last,
                         input logic [31:0] tdo_d, input logic [31:0] tdo_v, input int pause_rise,
                         input logic [31:0] exp_tdo, input logic exp_und, input int exp_lat,
                         input string tag);
    bit ok;
    int n, k, rises, last_rise, trst_low, seq_err, per_err, freeze_err, rsp_err, dly;
    logic prev_tck, hold_tms, hold_tdi;
    logic [39:0] snap;
    logic [31:0] snap_tdo;
    n = eff_len(op, len);
    send_cmd(op, len, tms, tdi, last, ok);
    k = 0; rises = 0; last_rise = 0; trst_low = 0;
    seq_err = 0; per_err = 0; freeze_err = 0; rsp_err = 0;
    prev_tck = 1'b0; hold_tms = 1'b0; hold_tdi = 1'b0;
    while (!rsp_valid && k < LIMIT) begin
      if (!jtag_TRSTn) trst_low++;
      if (jtag_TCK && !prev_tck) begin
        if (jtag_TMS !== model_tms(op, rises, n, tms, last) || jtag_TDI !== tdi[rises]) seq_err++;
        if (rises > 0 && pause_rise == 0 && (k - last_rise) != 2 * (cur_div + 1)) per_err++;
        last_rise = k; hold_tms = jtag_TMS; hold_tdi = jtag_TDI;
        rises++;
        if (rises == pause_rise) begin
          snap = {pins, rsp_tdo};
          enable = 1'b0;
          repeat (7) begin
            @(posedge clock); #1;
            k++;
            if ({pins, rsp_tdo} !== snap) freeze_err++;
          end
          enable = 1'b1;
        end
      end else if (jtag_TCK && (jtag_TMS !== hold_tms || jtag_TDI !== hold_tdi)) begin
        seq_err++;
      end
      prev_tck = jtag_TCK;
      if (rises < 32) begin
        jtag_TDO_data   = tdo_d[rises];
        jtag_TDO_driven = tdo_v[rises];
      end
      @(posedge clock); #1;
      k++;
    end
    check($sformatf("%s latency", tag), 64'(k), 64'(exp_lat + ((pause_rise != 0) ? 7 : 0)));
    check($sformatf("%s rsp_tdo", tag), 64'(rsp_tdo), 64'(exp_tdo));
    check($sformatf("%s rsp_undriven", tag), 64'(rsp_undriven), 64'(exp_und));
    check($sformatf("%s tck rises", tag), 64'(rises), 64'(n));
    check($sformatf("%s trst low clocks", tag), 64'(trst_low),
          64'((op == 2'd2) ? int'(len) * 2 * (cur_div + 1) : 0));
    check($sformatf("%s tms/tdi errors", tag), 64'(seq_err), 64'd0);
    check($sformatf("%s period errors", tag), 64'(per_err), 64'd0);
    if (pause_rise != 0) check($sformatf("%s frozen errors", tag), 64'(freeze_err), 64'd0);
    snap_tdo = rsp_tdo;
    dly = $urandom_range(0, 3);
    for (int j = 0; j < dly; j++) begin
      if (!rsp_valid || cmd_ready || rsp_tdo !== snap_tdo) rsp_err++;
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    if (cmd_ready || !rsp_valid) rsp_err++;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    if (rsp_valid || busy) rsp_err++;
    check($sformatf("%s response handshake errors", tag), 64'(rsp_err), 64'd0);
    if (op == 2'd3) cur_div = int'(tdi[15:0]);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] tms;
    logic [31:0] tdi;
    logic        last;
    logic [31:0] tdo_d;
    logic [31:0] tdo_v;
    logic [31:0] exp_tdo;
    logic        exp_und;
    int          exp_lat;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit ok;
    int err;
    logic [1:0]  r_op;
    logic [5:0]  r_len;
    logic [31:0] r_tms, r_tdi, r_d, r_v;
    logic        r_last;
    int          n;

    //         op    len    tms        tdi           last  tdo_d         tdo_v         exp_tdo       und   lat
    tbl[0]  = '{2'd0, 6'd1,  32'h0,     32'h1,        1'b0, 32'h1,        32'h1,        32'h1,        1'b0, 102};
    tbl[1]  = '{2'd3, 6'd0,  32'h0,     32'h1,        1'b0, 32'h0,        32'hF,        32'h0,        1'b0, 0};
    tbl[2]  = '{2'd0, 6'd4,  32'h0,     32'hA,        1'b1, 32'h6,        32'hF,        32'h6,        1'b0, 16};
    tbl[3]  = '{2'd3, 6'd0,  32'h0,     32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 0};
    tbl[4]  = '{2'd1, 6'd5,  32'h1F,    32'h0,        1'b0, 32'h0,        32'h1F,       32'h0,        1'b0, 10};
    tbl[5]  = '{2'd0, 6'd3,  32'h0,     32'h5,        1'b0, 32'h7,        32'h5,        32'h5,        1'b1, 6};
    tbl[6]  = '{2'd3, 6'd0,  32'h0,     32'h3,        1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 0};
    tbl[7]  = '{2'd2, 6'd2,  32'h0,     32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 16};
    tbl[8]  = '{2'd0, 6'd0,  32'h0,     32'hFF,       1'b1, 32'hFF,       32'hFF,       32'h0,        1'b0, 0};
    tbl[9]  = '{2'd3, 6'd0,  32'h0,     32'hABCD0000, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 0};
    tbl[10] = '{2'd0, 6'd40, 32'h0,     32'hDEADBEEF, 1'b0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0, 64};
    tbl[11] = '{2'd0, 6'd32, 32'h0,     32'h0,        1'b1, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFF0000, 1'b1, 64};
    tbl[12] = '{2'd1, 6'd1,  32'h0,     32'h1,        1'b1, 32'h1,        32'h1,        32'h1,        1'b0, 2};

    reset = 1'b0; enable = 1'b1; init_done = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_len = '0; cmd_tms = '0; cmd_tdi = '0; cmd_last = 1'b0;
    jtag_TDO_data = 1'b0; jtag_TDO_driven = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("reset pins", 64'(pins), 64'(8'b0101_0000));
    check("reset rsp_tdo", 64'(rsp_tdo), 64'd0);
    reset = 1'b1;
    err = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (cmd_ready) err++;
    end
    check("no cmd_ready before init_done", 64'(err), 64'd0);
    init_done = 1'b1;
    @(posedge clock); #1;
    init_done = 1'b0;
    check("cmd_ready after init_done", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      run_cmd(tbl[i].op, tbl[i].len, tbl[i].tms, tbl[i].tdi, tbl[i].last,
              tbl[i].tdo_d, tbl[i].tdo_v, 0, tbl[i].exp_tdo, tbl[i].exp_und, tbl[i].exp_lat,
              $sformatf("vec%0d", i));
    end

    // Pause during the HIGH phase of bit 1.
    run_cmd(2'd3, 6'd0, 32'h0, 32'h2, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0, 0, "pause setdiv");
    run_cmd(2'd0, 6'd3, 32'h0, 32'h3, 1'b0, 32'h2, 32'h7, 2, 32'h2, 1'b0, 18, "pause shift");

    // Reset in the middle of a SHIFT.
    send_cmd(2'd0, 6'd8, 32'h0, 32'h5A, 1'b1, ok);
    jtag_TDO_data = 1'b1; jtag_TDO_driven = 1'b1;
    repeat (10) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check("mid-shift reset pins", 64'(pins), 64'(8'b0101_0000));
    check("mid-shift reset rsp_tdo", 64'(rsp_tdo), 64'd0);
    err = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (cmd_ready || rsp_valid || busy) err++;
    end
    check("idle after mid-shift reset", 64'(err), 64'd0);
    init_done = 1'b1;
    @(posedge clock); #1;
    init_done = 1'b0;
    check("cmd_ready after second init_done", 64'(cmd_ready), 64'd1);
    cur_div = 50;

    for (int it = 0; it < 30; it++) begin
      r_op = (it == 0) ? 2'd3 : 2'($urandom_range(0, 3));
      r_len = (r_op == 2'd2) ? 6'($urandom_range(0, 4)) : 6'($urandom_range(0, 40));
      r_tms = $urandom; r_d = $urandom; r_v = $urandom | $urandom;
      r_last = 1'($urandom_range(0, 1));
      r_tdi = (r_op == 2'd3) ? {16'($urandom), 16'($urandom_range(0, 3))} : $urandom;
      n = eff_len(r_op, r_len);
      run_cmd(r_op, r_len, r_tms, r_tdi, r_last, r_d, r_v, 0,
              model_tdo(n, r_d, r_v), model_und(n, r_v), model_lat(r_op, r_len, cur_div),
              $sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_shift_engine.md
JTAG_SHIFT_ENGINE -- requirements
Module: jtag_shift_engine

Interface
REQ-001 Parameter W, default 32: maximum bits per command.
REQ-002 Parameter DIV_W, default 16: half-period divider width.
REQ-003 Parameter TICK_DELAY, default 50: divider reset value.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; asserted when 0, sampled on the rising edge of clock.
REQ-006 enable  in  1  run/pause qualifier.
REQ-007 init_done  in  1  target-ready indication.
REQ-008 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-009 cmd_op  in  2  opcode: 0 SHIFT, 1 TMS_SEQ, 2 TRST, 3 SET_DIV.
REQ-010 cmd_len  in  $clog2(W)+1  bit count for SHIFT/TMS_SEQ; TCK periods for TRST.
REQ-011 cmd_tms, cmd_tdi  in  W each  TMS/TDI bits, LSB first; cmd_tdi[DIV_W-1:0] is the new divider for SET_DIV.
REQ-012 cmd_last  in  1  for SHIFT, TMS=1 on the final bit.
REQ-013 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-014 rsp_tdo  out  W  captured TDO, LSB first.
REQ-015 rsp_undriven  out  1  at least one bit was sampled while TDO was not driven.
REQ-016 jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn  out  1 each  registered JTAG pins.
REQ-017 jtag_TDO_data, jtag_TDO_driven  in  1 each  TDO value and its drive qualifier.
REQ-018 busy  out  1  set in any state other than IDLE.

Function
REQ-019 init_done_sticky is set by init_done and cleared only by reset.
REQ-020 cmd_ready=1 only in IDLE, with init_done_sticky=1 and enable=1.
REQ-021 Divider behaviour: a half-period tick occurs after div+1 enabled clocks; the counter reloads on each state entry.
REQ-022 enable=0 freezes the counter, FSM and all outputs; no handshake completes while paused.
REQ-023 FSM states: IDLE, LOW, HIGH, TRST, RSP.
REQ-024 SHIFT/TMS_SEQ accepted at cycle T: at T+1 enter LOW with TCK=0 and bit 0 on TMS/TDI.
REQ-025 LOW transitions to HIGH on tick.
  - TCK=1.
  - TDO is sampled into rsp_tdo[i] in the same cycle.
REQ-026 HIGH transitions on tick: to LOW with bit i+1 if bits remain, else to RSP with TCK=0.
REQ-027 Each bit takes exactly 2*(div+1) clocks.
REQ-028 TMS value per bit:
  - SHIFT: TMS=0 except the final bit, where TMS=cmd_last.
  - TMS_SEQ: TMS=cmd_tms[i].
REQ-029 TDI=cmd_tdi[i] for both shift ops.
REQ-030 An undriven sample stores 0 and sets rsp_undriven.
REQ-031 Length handling:
  - cmd_len > W is clamped to W.
  - cmd_len = 0 goes directly to RSP at T+1, with rsp_tdo=0 and no TCK edge.
REQ-032 TRST: TRSTn=0 and TCK=0 for cmd_len*2*(div+1) clocks, then TRSTn=1 and the FSM enters RSP.
REQ-033 SET_DIV loads div at T+1, then enters RSP with rsp_tdo=0.
REQ-034 Every accepted command yields exactly one response, in order.
REQ-035 RSP holds rsp_valid=1 and stable data until rsp_ready; on handshake the FSM returns to IDLE.
  - cmd_ready is never asserted in the handshake cycle.
REQ-036 div=0 is legal; the TCK period is then 2 clocks.
REQ-037 TMS/TDI change only when entering LOW, never while TCK=1.

Reset
REQ-038 Reset values:
  - TCK=0, TMS=1, TDI=0, TRSTn=1.
  - cmd_ready=0, rsp_valid=0, rsp_tdo=0, rsp_undriven=0, busy=0.
  - div=TICK_DELAY, init_done_sticky=0, state IDLE.
REQ-039 Reset mid-command aborts the command: no response, and pins return to reset values in the next cycle.

Structure
REQ-040 Package jtag_shift_pkg holds the opcode enum, the FSM state enum, and the default constants for W, DIV_W and TICK_DELAY.
REQ-041 One sub-module, jtag_tck_divider, holds the counter, the reload/freeze inputs and the tick output.

Verification
REQ-042 Scenario: SET_DIV 1, then SHIFT len=4, tdi=0xA, cmd_last=1, TDO driven with 0b0110.
  - TCK period is 4 clocks.
  - TDI sequence is 0,1,0,1.
  - TMS sequence is 0,0,0,1.
  - rsp_tdo=0x6, rsp_undriven=0.
REQ-043 Scenario: TMS_SEQ len=5, tms=0x1F, div=0.
  - Five TMS=1 bits, 10 clocks.
  - One response.
REQ-044 Scenario: SHIFT len=3, jtag_TDO_driven=0 on bit 1.
  - rsp_tdo[1]=0.
  - rsp_undriven=1.
REQ-045 Scenario: TRST len=2, div=3.
  - TRSTn low for exactly 16 clocks.
  - TCK stays 0 throughout.
REQ-046 Scenario: enable deasserted for 7 clocks mid-HIGH.
  - All outputs frozen.
  - Completion is delayed by exactly 7 clocks.
REQ-047 Scenario: reset asserted mid-SHIFT, with rsp_ready held 0 after reset.
  - Reset values appear on the next cycle.
  - No rsp_valid.
  - cmd_ready stays 0 until init_done is seen.
